// File: rtl/scan_seq_if.sv
// rtl/scan_seq_if.sv - scan sequencer control/select bundle
// master drives run/mask, slave returns the decoder select, enable and frame pulse.
interface scan_seq_if;
  logic       run;
  logic [3:0] mask;
  logic       a;
  logic       b;
  logic       E;
  logic [1:0] idx;
  logic       frame_done;

  modport master (output run, output mask,
                  input a, input b, input E, input idx, input frame_done);
  modport slave  (input run, input mask,
                  output a, output b, output E, output idx, output frame_done);
endinterface

// File: rtl/scan_seq.sv
// rtl/scan_seq.sv - digit-scan sequencer feeding a 2-to-4 decoder
// Steps idx over enabled digits with DIV show cycles and BLANK dark cycles per slot.
module scan_seq #(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_seq_if.slave  bus
);

  localparam int CMAX = (DIV > BLANK) ? ((DIV > 2) ? DIV : 2) : ((BLANK > 2) ? BLANK : 2);
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_BLANK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          e_q, e_d;
  logic          fd_q, fd_d;
  logic          abort;
  logic [1:0]    adv_idx;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_set = 2'(i);
  endfunction

  // Search cur+1..cur+4; descending loop so the nearest candidate wins.
  function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] cand;
    next_set = cur;
    for (int k = 4; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (m[cand]) next_set = cand;
    end
  endfunction

  assign abort   = !bus.run || (bus.mask == 4'b0000);
  assign adv_idx = next_set(idx_q, bus.mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      e_q     <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    e_d     = e_q;
    fd_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = 2'd0;
        e_d   = 1'b0;
        if (!abort) begin
          state_d = ST_SHOW;
          idx_d   = lowest_set(bus.mask);
          e_d     = 1'b1;
        end
      end
      ST_SHOW, ST_BLANK: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
          e_d     = 1'b0;
        end else if (state_q == ST_SHOW && cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (state_q == ST_BLANK && cnt_q != BLANK_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (state_q == ST_SHOW && BLANK > 0) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          // Advance; landing on an index not above the old one closes the frame.
          state_d = ST_SHOW;
          cnt_d   = '0;
          idx_d   = adv_idx;
          e_d     = 1'b1;
          fd_d    = (adv_idx <= idx_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
        e_d     = 1'b0;
      end
    endcase
  end

  assign bus.E          = e_q;
  assign bus.idx        = idx_q;
  assign bus.a          = idx_q[0];
  assign bus.b          = idx_q[1];
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_scan_seq.sv
// tb/tb_scan_seq.sv - directed bench for scan_seq
// dut0 uses DIV=4/BLANK=1, dut1 uses DIV=2/BLANK=0.
module tb_scan_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scan_seq_if bus0 ();
  scan_seq_if bus1 ();

  scan_seq #(.DIV(4), .BLANK(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  scan_seq #(.DIV(2), .BLANK(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] seq;
    int         n;
  } scan_vec_t;

  scan_vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dut0(input int want_idx, input logic want_e, input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus0.E === want_e && int'(bus0.idx) == want_idx) && n < budget);
    checks++;
    if (!(bus0.E === want_e && int'(bus0.idx) == want_idx)) begin
      errors++;
      $display("FAIL %s: timeout, got idx %0d E %0b expected idx %0d E %0b",
               name, bus0.idx, bus0.E, want_idx, want_e);
    end
  endtask

  task automatic check_out0(input string name, input int e, input int i, input int fd);
    check({name, ".E"}, int'(bus0.E), e);
    check({name, ".idx"}, int'(bus0.idx), i);
    check({name, ".ba"}, int'({bus0.b, bus0.a}), i);
    check({name, ".fd"}, int'(bus0.frame_done), fd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{mask: 4'b1111, seq: {2'd3, 2'd2, 2'd1, 2'd0}, n: 4};
    vecs[1] = '{mask: 4'b0101, seq: {2'd0, 2'd0, 2'd2, 2'd0}, n: 2};
    vecs[2] = '{mask: 4'b1000, seq: {2'd0, 2'd0, 2'd0, 2'd3}, n: 1};
    vecs[3] = '{mask: 4'b0110, seq: {2'd0, 2'd0, 2'd2, 2'd1}, n: 2};
    vecs[4] = '{mask: 4'b1010, seq: {2'd0, 2'd0, 2'd3, 2'd1}, n: 2};

    bus0.run = 1'b0; bus0.mask = 4'b0000;
    bus1.run = 1'b0; bus1.mask = 4'b0000;
    rst_n = 1'b0;
    #1;
    check_out0("reset", 0, 0, 0);
    check("reset.dut1_E", int'(bus1.E), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_out0("idle", 0, 0, 0);

    for (int v = 0; v < 5; v++) begin
      bus0.run  = 1'b1;
      bus0.mask = vecs[v].mask;
      for (int s = 0; s <= 2 * vecs[v].n; s++) begin
        for (int c = 0; c < 5; c++) begin
          tick();
          check_out0($sformatf("scan%0d.s%0d.c%0d", v, s, c),
                     (c < 4) ? 1 : 0,
                     int'(vecs[v].seq[2 * (s % vecs[v].n) +: 2]),
                     (c == 0 && s > 0 && (s % vecs[v].n) == 0) ? 1 : 0);
        end
      end
      bus0.run = 1'b0;
      tick();
      check_out0($sformatf("stop%0d", v), 0, 0, 0);
    end

    // Async reset mid-SHOW of digit 2, no clock edge involved.
    bus0.run  = 1'b1;
    bus0.mask = 4'b1111;
    wait_dut0(2, 1'b1, 30, "reach_idx2");
    #2;
    rst_n = 1'b0;
    #1;
    check_out0("async_rst", 0, 0, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check_out0("rst_restart", 1, 0, 0);

    // Drop run in the second SHOW cycle of digit 1.
    wait_dut0(1, 1'b1, 30, "reach_idx1");
    tick();
    check_out0("abort_pre", 1, 1, 0);
    bus0.run = 1'b0;
    tick();
    check_out0("abort_run", 0, 0, 0);
    bus0.run = 1'b1;
    tick();
    check_out0("restart", 1, 0, 0);

    // Clear mask during BLANK.
    wait_dut0(0, 1'b0, 10, "reach_blank");
    bus0.mask = 4'b0000;
    tick();
    check_out0("abort_mask", 0, 0, 0);
    tick();
    check_out0("idle_mask0", 0, 0, 0);
    bus0.mask = 4'b0110;
    tick();
    check_out0("restart_0110", 1, 1, 0);

    // Clearing the current digit mid-slot keeps the full slot.
    bus0.mask = 4'b0100;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_out0($sformatf("midclr.t%0d", t),
                 (t == 4 || t == 9) ? 0 : 1,
                 (t < 5) ? 1 : 2,
                 (t == 10) ? 1 : 0);
    end
    bus0.run = 1'b0;
    tick();
    check_out0("midclr_stop", 0, 0, 0);

    // No blanking: DIV=2, BLANK=0.
    bus1.run  = 1'b1;
    bus1.mask = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("noblank.c%0d.E", c), int'(bus1.E), 1);
      check($sformatf("noblank.c%0d.idx", c), int'(bus1.idx), (c / 2) % 2);
      check($sformatf("noblank.c%0d.fd", c), int'(bus1.frame_done),
            (c > 0 && (c % 4) == 0) ? 1 : 0);
    end
    bus1.run = 1'b0;
    tick();
    check("noblank_stop.E", int'(bus1.E), 0);
    check("noblank_stop.idx", int'(bus1.idx), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
